avalon_bus_arbiter: RTL and testbench

Two-master, one-slave arbiter for the Avalon memory-mapped bus. It lets the CPU bus master (m0) and a second master (m1) share a single memory slave. Typical m1 sources are a test-bench program loader, a DMA engine, or a debug port. It grants one master at a time using round-robin, holds the grant until that transfer completes, and aborts transfers that stall past a watchdog limit.

---
 rtl/avalon_bus_arbiter_pkg.sv | 12 +
 rtl/avalon_bus_arbiter_rr_pick.sv | 19 +
 rtl/avalon_bus_arbiter.sv | 161 ++++++++++++++++
 tb/tb_avalon_bus_arbiter.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/avalon_bus_arbiter_pkg.sv
// Shared types and constants for the two-master Avalon-MM arbiter.
package avalon_bus_arbiter_pkg;

   typedef enum logic [1:0] {
      ARB_IDLE = 2'd0,
      ARB_M0   = 2'd1,
      ARB_M1   = 2'd2
   } arb_state_t;

   localparam logic [31:0] ARB_ABORT_DATA = 32'hDEAD_BEEF;

endpackage

// File: rtl/avalon_bus_arbiter_rr_pick.sv
// Two-way round-robin picker: a sole requester wins, a tie goes to the
// requester that did not own the bus last.
module arb_rr_pick (
   input  logic [1:0] req,
   input  logic       last_grant,
   output logic [1:0] pick
);

   always_comb begin
      pick = 2'b00;
      case (req)
         2'b01:   pick = 2'b01;
         2'b10:   pick = 2'b10;
         2'b11:   pick = last_grant ? 2'b01 : 2'b10;
         default: pick = 2'b00;
      endcase
   end

endmodule

// File: rtl/avalon_bus_arbiter.sv
// Two-master, one-slave Avalon-MM arbiter with round-robin grant,
// hold-until-complete ownership and a slave-stall watchdog.
module avalon_bus_arbiter
   import avalon_bus_arbiter_pkg::*;
#(
   parameter int                ADDR_W     = 32,
   parameter int                DATA_W     = 32,
   parameter int                MAX_WAIT   = 1024,
   parameter logic [DATA_W-1:0] ABORT_DATA = ARB_ABORT_DATA
) (
   input  logic                clk,
   input  logic                reset,
   input  logic [ADDR_W-1:0]   m0_address,
   input  logic                m0_read,
   input  logic                m0_write,
   input  logic [DATA_W-1:0]   m0_writedata,
   input  logic [DATA_W/8-1:0] m0_byteenable,
   output logic                m0_waitrequest,
   output logic [DATA_W-1:0]   m0_readdata,
   input  logic [ADDR_W-1:0]   m1_address,
   input  logic                m1_read,
   input  logic                m1_write,
   input  logic [DATA_W-1:0]   m1_writedata,
   input  logic [DATA_W/8-1:0] m1_byteenable,
   output logic                m1_waitrequest,
   output logic [DATA_W-1:0]   m1_readdata,
   output logic [ADDR_W-1:0]   s_address,
   output logic                s_read,
   output logic                s_write,
   output logic [DATA_W-1:0]   s_writedata,
   output logic [DATA_W/8-1:0] s_byteenable,
   input  logic                s_waitrequest,
   input  logic [DATA_W-1:0]   s_readdata,
   output logic [1:0]          grant,
   output logic                timeout_err,
   output arb_state_t          state_dbg
);

   localparam int CNT_W = (MAX_WAIT > 1) ? $clog2(MAX_WAIT) : 1;

   arb_state_t       state_q, state_d;
   logic             last_grant_q, last_grant_d;
   logic [CNT_W-1:0] wait_cnt_q, wait_cnt_d;
   logic             timeout_err_q, timeout_err_d;
   logic [1:0]       req;
   logic [1:0]       pick;
   logic             own_req;
   logic             wd_hit;

   assign req = {m1_read | m1_write, m0_read | m0_write};

   arb_rr_pick u_pick (
      .req        (req),
      .last_grant (last_grant_q),
      .pick       (pick)
   );

   always_comb begin
      own_req = 1'b0;
      case (state_q)
         ARB_M0:  own_req = req[0];
         ARB_M1:  own_req = req[1];
         default: own_req = 1'b0;
      endcase
   end

   // Last tolerated stall cycle: the owner is released with ABORT_DATA instead.
   assign wd_hit = (MAX_WAIT != 0) && own_req && s_waitrequest &&
                   (wait_cnt_q == CNT_W'(MAX_WAIT - 1));

   always_comb begin
      state_d       = state_q;
      last_grant_d  = last_grant_q;
      wait_cnt_d    = wait_cnt_q;
      timeout_err_d = timeout_err_q;
      case (state_q)
         ARB_IDLE: begin
            wait_cnt_d = '0;
            if (pick[0]) begin
               state_d      = ARB_M0;
               last_grant_d = 1'b0;
            end else if (pick[1]) begin
               state_d      = ARB_M1;
               last_grant_d = 1'b1;
            end
         end
         ARB_M0, ARB_M1: begin
            if (!own_req || !s_waitrequest) begin
               state_d    = ARB_IDLE;
               wait_cnt_d = '0;
            end else if (wd_hit) begin
               state_d       = ARB_IDLE;
               wait_cnt_d    = '0;
               timeout_err_d = 1'b1;
            end else begin
               wait_cnt_d = wait_cnt_q + 1'b1;
            end
         end
         default: state_d = ARB_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q       <= ARB_IDLE;
         last_grant_q  <= 1'b1;
         wait_cnt_q    <= '0;
         timeout_err_q <= 1'b0;
      end else begin
         state_q       <= state_d;
         last_grant_q  <= last_grant_d;
         wait_cnt_q    <= wait_cnt_d;
         timeout_err_q <= timeout_err_d;
      end
   end

   always_comb begin
      s_address      = '0;
      s_read         = 1'b0;
      s_write        = 1'b0;
      s_writedata    = '0;
      s_byteenable   = '0;
      m0_waitrequest = 1'b1;
      m1_waitrequest = 1'b1;
      m0_readdata    = '0;
      m1_readdata    = '0;
      case (state_q)
         ARB_M0: begin
            s_address      = m0_address;
            s_read         = m0_read & ~wd_hit;
            s_write        = m0_write & ~wd_hit;
            s_writedata    = m0_writedata;
            s_byteenable   = m0_byteenable;
            m0_waitrequest = wd_hit ? 1'b0 : s_waitrequest;
            m0_readdata    = wd_hit ? ABORT_DATA : s_readdata;
         end
         ARB_M1: begin
            s_address      = m1_address;
            s_read         = m1_read & ~wd_hit;
            s_write        = m1_write & ~wd_hit;
            s_writedata    = m1_writedata;
            s_byteenable   = m1_byteenable;
            m1_waitrequest = wd_hit ? 1'b0 : s_waitrequest;
            m1_readdata    = wd_hit ? ABORT_DATA : s_readdata;
         end
         default: ;
      endcase
      // Reset kills strobes in the same cycle, before the state register clears.
      if (reset) begin
         s_read         = 1'b0;
         s_write        = 1'b0;
         m0_waitrequest = 1'b1;
         m1_waitrequest = 1'b1;
      end
   end

   assign grant       = {state_q == ARB_M1, state_q == ARB_M0};
   assign timeout_err = timeout_err_q;
   assign state_dbg   = state_q;

endmodule

// File: tb/tb_avalon_bus_arbiter.sv
// Directed bench for avalon_bus_arbiter: single read, fairness, stalled
// write, watchdog abort, reset mid-transfer and dropped request.
module tb_avalon_bus_arbiter;
   import avalon_bus_arbiter_pkg::*;

   logic        clk;
   logic        reset;
   logic [31:0] m0_address, m1_address, s_address;
   logic        m0_read, m0_write, m1_read, m1_write, s_read, s_write;
   logic [31:0] m0_writedata, m1_writedata, s_writedata;
   logic [3:0]  m0_byteenable, m1_byteenable, s_byteenable;
   logic        m0_waitrequest, m1_waitrequest, s_waitrequest;
   logic [31:0] m0_readdata, m1_readdata, s_readdata;
   logic [1:0]  grant;
   logic        timeout_err;
   arb_state_t  state_dbg;

   int n_cmp = 0;
   int n_err = 0;

   avalon_bus_arbiter #(.ADDR_W(32), .DATA_W(32), .MAX_WAIT(8)) dut (
      .clk(clk), .reset(reset),
      .m0_address(m0_address), .m0_read(m0_read), .m0_write(m0_write),
      .m0_writedata(m0_writedata), .m0_byteenable(m0_byteenable),
      .m0_waitrequest(m0_waitrequest), .m0_readdata(m0_readdata),
      .m1_address(m1_address), .m1_read(m1_read), .m1_write(m1_write),
      .m1_writedata(m1_writedata), .m1_byteenable(m1_byteenable),
      .m1_waitrequest(m1_waitrequest), .m1_readdata(m1_readdata),
      .s_address(s_address), .s_read(s_read), .s_write(s_write),
      .s_writedata(s_writedata), .s_byteenable(s_byteenable),
      .s_waitrequest(s_waitrequest), .s_readdata(s_readdata),
      .grant(grant), .timeout_err(timeout_err), .state_dbg(state_dbg)
   );

   // Clock and reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // A master must never raise read and write together.
   always @(posedge clk) begin
      if (!reset) begin
         assert (!(m0_read && m0_write)) else $error("m0 drives read and write together");
         assert (!(m1_read && m1_write)) else $error("m1 drives read and write together");
      end
   end

   // Driver tasks
   task automatic drive_idle();
      m0_address = '0; m0_read = 0; m0_write = 0; m0_writedata = '0; m0_byteenable = '0;
      m1_address = '0; m1_read = 0; m1_write = 0; m1_writedata = '0; m1_byteenable = '0;
      s_waitrequest = 0; s_readdata = '0;
   endtask

   task automatic do_reset();
      @(posedge clk); #1;
      reset = 1'b1;
      drive_idle();
      @(posedge clk); #1;
      reset = 1'b0;
   endtask

   task automatic test_reset();
      do_reset();
      @(negedge clk);
      n_cmp++; if (grant !== 2'b00) begin n_err++; $display("FAIL rst_grant: got %b want 00", grant); end
      n_cmp++; if (state_dbg !== ARB_IDLE) begin n_err++; $display("FAIL rst_state: got %0d want 0", state_dbg); end
      n_cmp++; if (timeout_err !== 1'b0) begin n_err++; $display("FAIL rst_timeout: got %b want 0", timeout_err); end
      n_cmp++; if ({m0_waitrequest, m1_waitrequest} !== 2'b11) begin n_err++; $display("FAIL rst_wait: got %b want 11", {m0_waitrequest, m1_waitrequest}); end
      n_cmp++; if ({s_read, s_write} !== 2'b00) begin n_err++; $display("FAIL rst_strobes: got %b want 00", {s_read, s_write}); end
   endtask

   task automatic test_single_read();
      @(posedge clk); #1;
      m0_address = 32'hBFC0_0000; m0_read = 1; m0_byteenable = 4'hF;
      s_waitrequest = 0; s_readdata = 32'h3C02_0001;
      @(negedge clk);
      n_cmp++; if (grant !== 2'b00) begin n_err++; $display("FAIL rd_c1_grant: got %b want 00", grant); end
      n_cmp++; if (m0_waitrequest !== 1'b1 || s_read !== 1'b0) begin n_err++; $display("FAIL rd_c1_idle: got wait=%b s_read=%b want 1 0", m0_waitrequest, s_read); end
      @(negedge clk);
      n_cmp++; if (grant !== 2'b01) begin n_err++; $display("FAIL rd_c2_grant: got %b want 01", grant); end
      n_cmp++; if (m0_waitrequest !== 1'b0) begin n_err++; $display("FAIL rd_c2_wait: got %b want 0", m0_waitrequest); end
      n_cmp++; if (m0_readdata !== 32'h3C02_0001) begin n_err++; $display("FAIL rd_c2_data: got %h want 3c020001", m0_readdata); end
      n_cmp++; if (s_read !== 1'b1 || s_address !== 32'hBFC0_0000) begin n_err++; $display("FAIL rd_c2_slave: got rd=%b addr=%h want 1 bfc00000", s_read, s_address); end
      n_cmp++; if (m1_waitrequest !== 1'b1 || m1_readdata !== 32'h0) begin n_err++; $display("FAIL rd_c2_other: got wait=%b data=%h want 1 0", m1_waitrequest, m1_readdata); end
      @(posedge clk); #1;
      drive_idle();
      @(negedge clk);
      n_cmp++; if (grant !== 2'b00) begin n_err++; $display("FAIL rd_c3_grant: got %b want 00", grant); end
   endtask

   task automatic test_fairness();
      logic [1:0] exp_g [5];
      exp_g[0] = 2'b01; exp_g[1] = 2'b00; exp_g[2] = 2'b10; exp_g[3] = 2'b00; exp_g[4] = 2'b01;
      do_reset();
      m0_read = 1; m0_address = 32'h10; m1_read = 1; m1_address = 32'h20; s_waitrequest = 0;
      @(negedge clk);
      n_cmp++; if (grant !== 2'b00) begin n_err++; $display("FAIL rr_first_idle: got %b want 00", grant); end
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         n_cmp++; if (grant !== exp_g[i]) begin n_err++; $display("FAIL rr_seq[%0d]: got %b want %b", i, grant, exp_g[i]); end
      end
      @(posedge clk); #1;
      drive_idle();
      repeat (2) @(posedge clk);
   endtask

   task automatic test_stall_write();
      @(posedge clk); #1;
      m1_address = 32'h1000; m1_write = 1; m1_writedata = 32'hCAFE_F00D; m1_byteenable = 4'b0011;
      s_waitrequest = 1;
      @(negedge clk);
      n_cmp++; if (grant !== 2'b00) begin n_err++; $display("FAIL wr_idle_grant: got %b want 00", grant); end
      for (int i = 1; i <= 4; i++) begin
         @(posedge clk); #1;
         s_waitrequest = (i == 4) ? 1'b0 : 1'b1;
         @(negedge clk);
         n_cmp++; if (grant !== 2'b10) begin n_err++; $display("FAIL wr_grant[%0d]: got %b want 10", i, grant); end
         n_cmp++; if (s_write !== 1'b1 || s_read !== 1'b0 || s_address !== 32'h1000 || s_writedata !== 32'hCAFE_F00D || s_byteenable !== 4'b0011) begin
            n_err++; $display("FAIL wr_slave[%0d]: got wr=%b rd=%b addr=%h data=%h be=%b", i, s_write, s_read, s_address, s_writedata, s_byteenable);
         end
         n_cmp++; if (m1_waitrequest !== (i != 4)) begin n_err++; $display("FAIL wr_m1wait[%0d]: got %b want %b", i, m1_waitrequest, (i != 4)); end
         n_cmp++; if (m0_waitrequest !== 1'b1) begin n_err++; $display("FAIL wr_m0wait[%0d]: got %b want 1", i, m0_waitrequest); end
      end
      @(posedge clk); #1;
      drive_idle();
      @(negedge clk);
      n_cmp++; if (grant !== 2'b00) begin n_err++; $display("FAIL wr_done_grant: got %b want 00", grant); end
      @(posedge clk);
   endtask

   task automatic test_watchdog();
      @(posedge clk); #1;
      m0_address = 32'h2000; m0_read = 1; m0_byteenable = 4'hF;
      s_waitrequest = 1; s_readdata = 32'h1234_5678;
      @(negedge clk);
      for (int i = 1; i <= 8; i++) begin
         @(negedge clk);
         n_cmp++; if (grant !== 2'b01) begin n_err++; $display("FAIL wd_grant[%0d]: got %b want 01", i, grant); end
         n_cmp++; if (m0_waitrequest !== (i != 8)) begin n_err++; $display("FAIL wd_wait[%0d]: got %b want %b", i, m0_waitrequest, (i != 8)); end
         n_cmp++; if (s_read !== (i != 8)) begin n_err++; $display("FAIL wd_sread[%0d]: got %b want %b", i, s_read, (i != 8)); end
         n_cmp++; if (timeout_err !== 1'b0) begin n_err++; $display("FAIL wd_early_flag[%0d]: got %b want 0", i, timeout_err); end
      end
      n_cmp++; if (m0_readdata !== 32'hDEAD_BEEF) begin n_err++; $display("FAIL wd_abort_data: got %h want deadbeef", m0_readdata); end
      @(posedge clk); #1;
      drive_idle();
      @(negedge clk);
      n_cmp++; if (grant !== 2'b00 || timeout_err !== 1'b1) begin n_err++; $display("FAIL wd_after: got grant=%b flag=%b want 00 1", grant, timeout_err); end
      repeat (3) @(negedge clk);
      n_cmp++; if (timeout_err !== 1'b1) begin n_err++; $display("FAIL wd_sticky: got %b want 1", timeout_err); end
      do_reset();
      @(negedge clk);
      n_cmp++; if (timeout_err !== 1'b0) begin n_err++; $display("FAIL wd_cleared: got %b want 0", timeout_err); end
   endtask

   task automatic test_reset_mid();
      @(posedge clk); #1;
      m1_address = 32'h3000; m1_read = 1; m1_byteenable = 4'hF; s_waitrequest = 1;
      @(negedge clk);
      @(negedge clk);
      n_cmp++; if (grant !== 2'b10 || s_read !== 1'b1) begin n_err++; $display("FAIL rm_stall1: got grant=%b s_read=%b want 10 1", grant, s_read); end
      @(posedge clk); #1;
      reset = 1'b1;
      m0_address = 32'h4000; m0_read = 1; m0_byteenable = 4'hF;
      @(negedge clk);
      n_cmp++; if (s_read !== 1'b0 || s_write !== 1'b0) begin n_err++; $display("FAIL rm_gate: got rd=%b wr=%b want 0 0", s_read, s_write); end
      n_cmp++; if ({m0_waitrequest, m1_waitrequest} !== 2'b11) begin n_err++; $display("FAIL rm_wait: got %b want 11", {m0_waitrequest, m1_waitrequest}); end
      @(posedge clk); #1;
      reset = 1'b0;
      @(negedge clk);
      n_cmp++; if (grant !== 2'b00 || state_dbg !== ARB_IDLE) begin n_err++; $display("FAIL rm_idle: got grant=%b state=%0d want 00 0", grant, state_dbg); end
      @(negedge clk);
      n_cmp++; if (grant !== 2'b01) begin n_err++; $display("FAIL rm_tie: got %b want 01", grant); end
      @(posedge clk); #1;
      drive_idle();
      repeat (2) @(posedge clk);
   endtask

   task automatic test_drop();
      @(posedge clk); #1;
      m0_address = 32'h5000; m0_read = 1; m0_byteenable = 4'hF; s_waitrequest = 1;
      @(negedge clk);
      @(negedge clk);
      n_cmp++; if (grant !== 2'b01 || m0_waitrequest !== 1'b1) begin n_err++; $display("FAIL dr_granted: got grant=%b wait=%b want 01 1", grant, m0_waitrequest); end
      @(posedge clk); #1;
      m0_read = 0;
      @(negedge clk);
      n_cmp++; if (s_read !== 1'b0 || m0_waitrequest !== 1'b1) begin n_err++; $display("FAIL dr_drop: got s_read=%b wait=%b want 0 1", s_read, m0_waitrequest); end
      @(negedge clk);
      n_cmp++; if (grant !== 2'b00 || state_dbg !== ARB_IDLE) begin n_err++; $display("FAIL dr_idle: got grant=%b state=%0d want 00 0", grant, state_dbg); end
      n_cmp++; if (timeout_err !== 1'b0) begin n_err++; $display("FAIL dr_flag: got %b want 0", timeout_err); end
      drive_idle();
   endtask

   initial begin
      reset = 1'b1;
      drive_idle();
      test_reset();
      test_single_read();
      test_fairness();
      test_stall_write();
      test_watchdog();
      test_reset_mid();
      test_drop();
      repeat (2) @(posedge clk);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
